// File: rtl/y86_exec_seq_if.sv
// Bus bundle for the Y86-64 execute sequencer: the decode-side instruction
// handshake, the shared ALU operand/result bus and the memory-side result
// handshake.
//
// Handshake rule, both directions: a transfer happens on a rising edge where
// valid and ready are both high. Once valid is raised, the payload is held
// stable and valid stays high until that transfer. ready may change freely.
interface y86_exec_seq_if;
  // decode -> sequencer
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  // sequencer <-> shared ALU
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [1:0]  alu_fun;
  logic [63:0] alu_valE;
  logic [2:0]  alu_cf;
  // sequencer -> memory stage
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  cc;
  logic        bad_op;

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, alu_valE, alu_cf, out_ready,
    output in_ready, alu_a, alu_b, alu_fun, out_valid, valE, cnd, cc, bad_op
  );

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, alu_valE, alu_cf, out_ready,
    input  in_ready, alu_a, alu_b, alu_fun, out_valid, valE, cnd, cc, bad_op
  );
endinterface

// File: rtl/y86_exec_seq.sv
// Y86-64 execute-stage sequencer. Takes one decoded instruction, drives the
// shared ALU, waits ALU_LAT cycles for it to settle, captures valE, updates
// the condition codes for OPq and evaluates cnd for cmovXX/jXX.
module y86_exec_seq #(
  parameter int ALU_LAT = 2,   // ALU settle cycles, 1..15
  parameter int SP_STEP = 8    // stack pointer adjust magnitude
) (
  input  logic              clk,
  input  logic              rst,
  y86_exec_seq_if.slave     bus,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_in_ready;
  logic        w_out_valid;

  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_cnt;
  logic [63:0] r_alu_a;
  logic [63:0] r_alu_b;
  logic [1:0]  r_alu_fun;
  logic [63:0] r_valE;
  logic        r_cnd;
  logic        r_bad;
  logic [2:0]  r_cc;   // {ZF,SF,OF}

  logic [63:0] w_sel_a;
  logic [63:0] w_sel_b;
  logic [1:0]  w_sel_fun;
  logic        w_cnd;
  logic        w_bad;
  logic        w_null;
  logic        w_cc_load;

  localparam logic [63:0] SP_POS = 64'(SP_STEP);
  localparam logic [63:0] SP_NEG = (~SP_POS) + 64'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_EVAL;
      end
      ST_EVAL:   if (r_cnt == 4'd0) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_OUT;
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Operand and function select from the incoming icode/ifun.
  always_comb begin
    w_sel_a   = 64'd0;
    w_sel_b   = 64'd0;
    w_sel_fun = 2'd0;
    case (bus.icode)
      4'h2:             w_sel_a = bus.valA;
      4'h6:             w_sel_a = bus.valA;
      4'h3, 4'h4, 4'h5: w_sel_a = bus.valC;
      4'h8, 4'hA:       w_sel_a = SP_NEG;
      4'h9, 4'hB:       w_sel_a = SP_POS;
      default:          w_sel_a = 64'd0;
    endcase
    case (bus.icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_sel_b = bus.valB;
      default:                                  w_sel_b = 64'd0;
    endcase
    if (bus.icode == 4'h6) w_sel_fun = bus.ifun[1:0];
  end

  // Condition evaluation against the CC held before this op, plus op legality.
  always_comb begin
    w_cnd     = 1'b0;
    w_bad     = 1'b0;
    w_null    = 1'b0;
    w_cc_load = (r_icode == 4'h6) && (r_ifun <= 4'd3);
    if ((r_icode == 4'h2) || (r_icode == 4'h7)) begin
      case (r_ifun)
        4'd0:    w_cnd = 1'b1;
        4'd1:    w_cnd = (r_cc[1] ^ r_cc[0]) | r_cc[2];
        4'd2:    w_cnd = r_cc[1] ^ r_cc[0];
        4'd3:    w_cnd = r_cc[2];
        4'd4:    w_cnd = ~r_cc[2];
        4'd5:    w_cnd = ~(r_cc[1] ^ r_cc[0]);
        4'd6:    w_cnd = ~(r_cc[1] ^ r_cc[0]) & ~r_cc[2];
        default: w_cnd = 1'b0;
      endcase
    end
    case (r_icode)
      4'h2, 4'h7:                         w_bad = (r_ifun > 4'd6);
      4'h6:                               w_bad = (r_ifun > 4'd3);
      4'h0, 4'h1, 4'hC, 4'hD, 4'hE, 4'hF: begin
        w_bad  = 1'b1;
        w_null = 1'b1;
      end
      default:                            w_bad = 1'b0;
    endcase
  end

  // Datapath: latch on accept, count settle cycles, capture on COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_icode   <= 4'd0;
      r_ifun    <= 4'd0;
      r_cnt     <= 4'd0;
      r_alu_a   <= 64'd0;
      r_alu_b   <= 64'd0;
      r_alu_fun <= 2'd0;
      r_valE    <= 64'd0;
      r_cnd     <= 1'b0;
      r_bad     <= 1'b0;
      r_cc      <= 3'b100;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_icode   <= bus.icode;
            r_ifun    <= bus.ifun;
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_fun <= w_sel_fun;
            r_cnt     <= 4'(ALU_LAT - 1);
          end
        end
        ST_EVAL: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        ST_COMMIT: begin
          r_valE <= w_null ? 64'd0 : bus.alu_valE;
          r_cnd  <= w_cnd;
          r_bad  <= w_bad;
          if (w_cc_load) r_cc <= bus.alu_cf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_fun   = r_alu_fun;
  assign bus.valE      = r_valE;
  assign bus.cnd       = r_cnd;
  assign bus.bad_op    = r_bad;
  assign bus.cc        = r_cc;
  assign o_state       = r_state;

endmodule

// File: doc/y86_exec_seq.md
Name: y86_exec_seq

Overview:
- Multi-cycle sequencer for the Y86-64 execute stage.
- Accepts one decoded instruction from decode over a valid/ready handshake.
- Drives operand select and function code into the shared 64-bit ripple ALU, waits ALU_LAT cycles for it to settle, then captures valE.
- Owns the architectural condition-code register (ZF/SF/OF) and produces cnd for cmovXX/jXX; presents the result to the memory stage over valid/ready.

Parameters:
- ALU_LAT, 2, settle cycles allowed for the external ALU (legal range 1..15).
- SP_STEP, 8, stack-pointer adjust magnitude for call/ret/push/pop.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  sequencer can accept
- icode  in  4  instruction code
- ifun  in  4  function code
- valA  in  64  decoded rA value
- valB  in  64  decoded rB value
- valC  in  64  immediate
- alu_a  out  64  ALU operand A
- alu_b  out  64  ALU operand B
- alu_fun  out  2  0 add, 1 sub (B−A), 2 and, 3 xor
- alu_valE  in  64  ALU result
- alu_cf  in  3  ALU flags {ZF,SF,OF} = bits [2:0]
- out_valid  out  1  result valid to memory stage
- out_ready  in  1  memory stage accepts
- valE  out  64  captured result
- cnd  out  1  condition outcome
- cc  out  3  current {ZF,SF,OF}
- bad_op  out  1  unsupported icode/ifun for this op

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, valE=0, cnd=0, bad_op=0, cc=3'b100, alu_a=alu_b=0, alu_fun=0. Reset asserted in any state aborts the op and discards the result; CC returns to 3'b100.
- FSM states: IDLE → EVAL → COMMIT → OUT → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch icode/ifun/valA/valB/valC, drive ALU inputs, load counter to ALU_LAT−1, go to EVAL.
- EVAL:
  - in_ready=0.
  - Decrement the counter each cycle; go to COMMIT when it reaches 0.
- COMMIT (one cycle):
  - At the exiting edge, capture valE=alu_valE and compute cnd/bad_op.
  - If icode=6 and ifun≤3, also load cc=alu_cf.
  - Go to OUT.
- OUT:
  - out_valid=1; valE, cnd and bad_op are held stable.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
- Timing: for an op accepted at edge 0, out_valid is high after edge ALU_LAT+1. With an immediate out_ready, the op occupies ALU_LAT+2 cycles and in_ready returns after edge ALU_LAT+2. No overlap of ops.
- ALU inputs are held constant from acceptance until leaving OUT.
- Operand select (alu_a):
  - valA for icode 2 and 6.
  - valC for icode 3, 4, 5.
  - −SP_STEP (two's complement) for icode 8 and A.
  - +SP_STEP for icode 9 and B.
  - 0 otherwise.
- Operand select (alu_b):
  - valB for icode 4, 5, 6, 8, 9, A, B.
  - 0 otherwise.
- alu_fun = ifun[1:0] for icode 6; 0 (add) for all others.
- cnd:
  - Evaluated for icode 2 and 7 against the CC value held before this op.
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF)&~ZF.
  - All other icodes: cnd=0.
- bad_op=1 when:
  - icode 2 or 7 with ifun>6, or icode 6 with ifun>3: result still sequenced, cnd=0, CC unchanged.
  - icode in {0,1,C..F}: alu_a=alu_b=0, valE=0.
- All arithmetic is 64-bit modulo 2^64; the ALU output is used unmodified.

Test Plan:
- Reset, then OPq icode=6, valA=30, valB=50, ifun 0/1/2/3, ALU_LAT=2 → valE 80/20/18/44; out_valid rises exactly 3 edges after acceptance; cc updated each op (ZF=1 never).
- subq valA=50, valB=50 → valE=0, cc=3'b100; then jXX icode=7 ifun=3 → cnd=1, cc unchanged; ifun=4 → cnd=0.
- push icode=A, valB=0x100 → alu_a=0xFFFF_FFFF_FFFF_FFF8, valE=0xF8; pop icode=B, valB=0x100 → valE=0x108; rrmovq icode=2 ifun=0, valA=30 → valE=30, cnd=1.
- Hold out_ready=0 for 5 cycles in OUT → out_valid, valE and cnd stable; in_ready=0 throughout; in_valid pulses are ignored; release → one transfer only.
- Assert rst during EVAL after a prior subq set cc=3'b010 → next cycle IDLE, out_valid=0, cc=3'b100; no result emitted.
- icode=6 ifun=5 → bad_op=1, cc unchanged; icode=7 ifun=9 → bad_op=1, cnd=0.
